// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding, sync byte, default load address.
// PROG_LOADER_CHECKSUM_EN adds the CHECK state used for the trailing checksum byte.
package prog_loader_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LEN_W  = 16;

    localparam logic [BYTE_W-1:0] SYNC_BYTE         = 8'hA5;
    localparam logic [DATA_W-1:0] ADDR_BASE_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHECK = 3'd4,
`endif
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_wr_t;

    // Byte address of word idx; wraps modulo 2^32.
    function automatic logic [DATA_W-1:0] word_addr(input logic [DATA_W-1:0] base,
                                                    input logic [LEN_W-1:0]  idx);
        return base + {14'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte-to-word assembler: first byte lands in [7:0], fourth byte in [31:24].
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [DATA_W-1:0] word_c,
    output logic              word_done_c
);

    logic [1:0]  idx_q;
    logic [23:0] low_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
            low_q <= 24'd0;
        end else if (clear) begin
            idx_q <= 2'd0;
        end else if (byte_valid) begin
            idx_q <= idx_q + 2'd1;
            case (idx_q)
                2'd0:    low_q[7:0]   <= byte_data;
                2'd1:    low_q[15:8]  <= byte_data;
                2'd2:    low_q[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

    // The fourth byte bypasses the holding register so the word is ready on its accept edge.
    assign word_c      = {byte_data, low_q};
    assign word_done_c = byte_valid && (idx_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: sync byte, 16-bit word count, little-endian words into instruction memory.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before DONE.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [DATA_W-1:0] ADDR_BASE = ADDR_BASE_DEFAULT,
    parameter int unsigned       MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t ST_POST = ST_CHECK;
`else
    localparam state_t ST_POST = ST_DONE;
`endif

    state_t             state_q, state_d;
    logic               xfer;
    logic [LEN_W-1:0]   len_q, len_c, k_q;
    logic [DATA_W-1:0]  word_c;
    logic               word_done_c, last_word_c;
    mem_wr_t            mem_q;
    logic               in_ready_d, core_rst_d, done_d, error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]  csum_q;
`endif

    assign xfer        = in_valid && in_ready;
    assign len_c       = {in_data, len_q[7:0]};
    assign last_word_c = word_done_c && (k_q == len_q - LEN_W'(1));

    byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst),
        .clear       (state_q != ST_DATA),
        .byte_valid  (xfer && (state_q == ST_DATA)),
        .byte_data   (in_data),
        .word_c      (word_c),
        .word_done_c (word_done_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (xfer && (in_data == SYNC_BYTE)) state_d = ST_LEN0;
            ST_LEN0:  if (xfer) state_d = ST_LEN1;
            ST_LEN1: begin
                if (xfer) begin
                    if (32'(len_c) > MAX_WORDS) state_d = ST_ERROR;
                    else if (len_c == '0)       state_d = ST_POST;
                    else                        state_d = ST_DATA;
                end
            end
            ST_DATA:  if (last_word_c) state_d = ST_POST;
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHECK: if (xfer) state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
`endif
            ST_DONE:  if (start) state_d = ST_IDLE;
            ST_ERROR: if (start) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the upcoming state, then registered
    always_comb begin
        in_ready_d = 1'b0;
        core_rst_d = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        case (state_d)
            ST_DONE: begin
                core_rst_d = 1'b1;
                done_d     = 1'b1;
            end
            ST_ERROR: error_d    = 1'b1;
            default:  in_ready_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready <= 1'b0;
            core_rst <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            mem_we   <= 1'b0;
            mem_q    <= '0;
            len_q    <= '0;
            k_q      <= '0;
        end else begin
            in_ready <= in_ready_d;
            core_rst <= core_rst_d;
            done     <= done_d;
            error    <= error_d;
            mem_we   <= word_done_c;
            if (word_done_c) begin
                mem_q <= '{addr: word_addr(ADDR_BASE, k_q), data: word_c};
            end
            if (xfer && (state_q == ST_LEN0)) len_q[7:0]  <= in_data;
            if (xfer && (state_q == ST_LEN1)) len_q[15:8] <= in_data;
            if (state_q == ST_IDLE)  k_q <= '0;
            else if (word_done_c)    k_q <= k_q + LEN_W'(1);
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running XOR of every payload byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                 csum_q <= '0;
        else if (state_q == ST_IDLE)              csum_q <= '0;
        else if (xfer && (state_q == ST_DATA))    csum_q <= csum_q ^ in_data;
    end
`endif

    assign mem_addr = mem_q.addr;
    assign mem_wd   = mem_q.data;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; follows PROG_LOADER_CHECKSUM_EN when defined.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_we, core_rst, done, error;
    logic [31:0] mem_addr, mem_wd;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    logic [7:0]  prog [12] = '{8'h00, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h05,
                               8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
    logic [31:0] exp_addr [2] = '{32'h0000_0000, 32'h0000_0004};
    logic [31:0] exp_data [2] = '{32'h0050_0513, 32'h00A0_0593};

    prog_loader #(.ADDR_BASE(32'h0000_0000), .MAX_WORDS(1024)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .core_rst (core_rst),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // One entry per cycle mem_we is high, so a stretched strobe shows up as an extra write.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wd);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_byte: in_ready=%b required 1 for byte %h", in_ready, b);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_prog(input bit gaps);
        for (int i = 0; i < 12; i++) send_byte(prog[i], gaps);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h70, gaps);   // XOR of the eight payload bytes
`endif
    endtask

    task automatic wait_end(output bit ended);
        int n = 0;
        while (!(done || error) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        ended = done || error;
    endtask

    task automatic rearm();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, mem_we, core_rst, done, error} !== 5'b0 || mem_addr !== 32'h0 || mem_wd !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: rdy/we/crst/done/err=%b addr=%h wd=%h required all zero",
                     {in_ready, mem_we, core_rst, done, error}, mem_addr, mem_wd);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || core_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b core_rst=%b required 1 0", in_ready, core_rst);
        end
    endtask

    task automatic test_basic_load(input bit gaps, input string name);
        bit ended;
        wr_addr.delete(); wr_data.delete();
        send_prog(gaps);
        wait_end(ended);
        @(posedge clk); #1;
        checks++;
        if (!ended || done !== 1'b1 || core_rst !== 1'b1 || error !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b core_rst=%b error=%b in_ready=%b required 1 1 0 0",
                     name, done, core_rst, error, in_ready);
        end
        checks++;
        if (wr_addr.size() != 2) begin
            errors++;
            $display("FAIL %s_write_count: got %0d required 2", name, wr_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                    errors++;
                    $display("FAIL %s_write%0d: addr=%h data=%h required %h %h",
                             name, i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h4 || mem_wd !== 32'h00A0_0593) begin
            errors++;
            $display("FAIL %s_hold: we=%b addr=%h wd=%h required 0 00000004 00a00593",
                     name, mem_we, mem_addr, mem_wd);
        end
        rearm();
        checks++;
        if (done !== 1'b0 || core_rst !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_rearm: done=%b core_rst=%b in_ready=%b required 0 0 1",
                     name, done, core_rst, in_ready);
        end
    endtask

    task automatic test_zero_len();
        bit ended;
        wr_addr.delete(); wr_data.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b0);
`endif
        wait_end(ended);
        @(posedge clk); #1;
        checks++;
        if (!ended || done !== 1'b1 || error !== 1'b0 || wr_addr.size() != 0) begin
            errors++;
            $display("FAIL zero_len: done=%b error=%b writes=%0d required 1 0 0",
                     done, error, wr_addr.size());
        end
        rearm();
    endtask

    task automatic test_too_long();
        bit ended;
        wr_addr.delete(); wr_data.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h04, 1'b0);
        wait_end(ended);
        @(posedge clk); #1;
        checks++;
        if (!ended || error !== 1'b1 || done !== 1'b0 || core_rst !== 1'b0 || in_ready !== 1'b0 ||
            wr_addr.size() != 0) begin
            errors++;
            $display("FAIL too_long: error=%b done=%b core_rst=%b in_ready=%b writes=%0d required 1 0 0 0 0",
                     error, done, core_rst, in_ready, wr_addr.size());
        end
        rearm();
        checks++;
        if (error !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL too_long_rearm: error=%b in_ready=%b required 0 1", error, in_ready);
        end
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        bit ended;
        for (int i = 0; i < 12; i++) send_byte(prog[i], 1'b0);
        send_byte(8'hC1, 1'b0);
        wait_end(ended);
        checks++;
        if (!ended || error !== 1'b1 || done !== 1'b0 || core_rst !== 1'b0) begin
            errors++;
            $display("FAIL bad_checksum: error=%b done=%b core_rst=%b required 1 0 0", error, done, core_rst);
        end
        rearm();
    endtask
`endif

    task automatic test_mid_reset();
        logic [7:0] head [5] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05};
        for (int i = 0; i < 5; i++) send_byte(head[i], 1'b0);
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, mem_we, core_rst, done, error} !== 5'b0 || mem_addr !== 32'h0 || mem_wd !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_values: rdy/we/crst/done/err=%b addr=%h wd=%h required all zero",
                     {in_ready, mem_we, core_rst, done, error}, mem_addr, mem_wd);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        test_basic_load(1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic_load(1'b0, "basic");
        test_zero_len();
        test_too_long();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_mid_reset();
        test_basic_load(1'b1, "random_valid");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
